// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiply unit.
//
// Contents:
//   MUL_OP / UMULL_OP / SMULL_OP  decoder ALU control codes for multiplies
//   mul_state_t                   sequencer states of mul_iter
//   MUL_CYCLES                    start-to-done latency of the full-length build
package mul_pkg;

    localparam logic [2:0] MUL_OP   = 3'b100;
    localparam logic [2:0] UMULL_OP = 3'b101;
    localparam logic [2:0] SMULL_OP = 3'b110;

    // Accept cycle is cycle 0; done is asserted in this cycle when every
    // multiplier bit is walked (32 RUN cycles plus the FIX cycle).
    localparam int unsigned MUL_CYCLES = 34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

endpackage

// File: rtl/mul_negate.sv
// Conditional two's-complement of a W-bit value.
//
// Parameters:
//   W       value width
// Ports:
//   en      1 = negate, 0 = pass through
//   value   input value
//   result  en ? -value : value (modulo 2^W)
module mul_negate #(
    parameter int unsigned W = 32
) (
    input  logic         en,
    input  logic [W-1:0] value,
    output logic [W-1:0] result
);

    always_comb begin
        result = value;
        if (en) begin
            result = {W{1'b0}} - value;
        end
    end

endmodule

// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier for the execute stage.
//
// Computes MUL (low word only), UMULL and SMULL (64-bit) products over
// several cycles. Signed multiplies run on operand magnitudes and the
// accumulated product is negated in the FIX cycle when the signs differ.
// Undefined MulCtrl codes execute as MUL.
//
// Build option:
//   MUL_EARLY_TERM_EN  when defined, RUN ends as soon as the remaining
//                      multiplier bits are all zero (latency 3..34 cycles);
//                      otherwise RUN always lasts WIDTH cycles (latency 34).
//                      Results and flags are identical in both builds.
//
// Parameters:
//   WIDTH     operand width; product width is 2*WIDTH
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-high
//   start     request, sampled only in IDLE
//   MulCtrl   3'b100 MUL, 3'b101 UMULL, 3'b110 SMULL
//   SrcA      multiplicand (Rn)
//   SrcB      multiplier (Rm)
//   busy      high in RUN and FIX
//   done      one-cycle pulse when results become valid
//   ResultLo  product low word
//   ResultHi  product high word (0 for MUL)
//   MulFlags  {N, Z}
module mul_iter
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       MulCtrl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       MulFlags
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    mul_state_t state;
    mul_state_t state_next;

    logic             long_q;
    logic             neg_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_q;
    logic [CW-1:0]    count_q;

    logic             is_long;
    logic             is_smull;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    acc_fix;
    logic             run_last;
    logic             flag_n;
    logic             flag_z;

    // ---------------------------------------------------------------
    // Operation decode (anything not UMULL/SMULL behaves as MUL)
    // ---------------------------------------------------------------
    always_comb begin
        is_long  = (MulCtrl == UMULL_OP) || (MulCtrl == SMULL_OP);
        is_smull = (MulCtrl == SMULL_OP);
    end

    mul_negate #(.W(WIDTH)) u_mag_a (
        .en     (is_smull && SrcA[WIDTH-1]),
        .value  (SrcA),
        .result (mag_a)
    );

    mul_negate #(.W(WIDTH)) u_mag_b (
        .en     (is_smull && SrcB[WIDTH-1]),
        .value  (SrcB),
        .result (mag_b)
    );

    mul_negate #(.W(PW)) u_fix (
        .en     (neg_q),
        .value  (acc_q),
        .result (acc_fix)
    );

    // ---------------------------------------------------------------
    // RUN exit condition
    // ---------------------------------------------------------------
`ifdef MUL_EARLY_TERM_EN
    // Stop once the shifted-out multiplier leaves nothing but zeros; the
    // remaining iterations could only add zero to the accumulator.
    always_comb begin
        run_last = (count_q == '0) || (mplier_q[WIDTH-1:1] == '0);
    end
`else
    always_comb begin
        run_last = (count_q == '0);
    end
`endif

    // ---------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (run_last) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Flags from the sign-corrected product
    // ---------------------------------------------------------------
    always_comb begin
        flag_n = acc_fix[WIDTH-1];
        flag_z = (acc_fix[WIDTH-1:0] == '0);
        if (long_q) begin
            flag_n = acc_fix[PW-1];
            flag_z = (acc_fix == '0);
        end
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            long_q   <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            ResultLo <= '0;
            ResultHi <= '0;
            MulFlags <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        long_q   <= is_long;
                        neg_q    <= is_smull && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                        acc_q    <= '0;
                        count_q  <= CW'(WIDTH - 1);
                    end
                end
                RUN: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (count_q != '0) begin
                        count_q <= count_q - 1'b1;
                    end
                end
                FIX: begin
                    ResultLo <= acc_fix[WIDTH-1:0];
                    ResultHi <= long_q ? acc_fix[PW-1:WIDTH] : '0;
                    MulFlags <= {flag_n, flag_z};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: expected products come from a
// behavioural reference model, are queued when an operation is issued and
// are compared against the DUT outputs in the done cycle.
module tb_mul_iter;
    import mul_pkg::*;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [1:0]  flags;
        int unsigned lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  MulCtrl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] ResultLo;
    logic [31:0] ResultHi;
    logic [1:0]  MulFlags;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    exp_t        sb[$];

    mul_iter #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .MulCtrl  (MulCtrl),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .busy     (busy),
        .done     (done),
        .ResultLo (ResultLo),
        .ResultHi (ResultHi),
        .MulFlags (MulFlags)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t               e;
        logic        [63:0] p;
        logic signed [63:0] sa;
        logic signed [63:0] sb_v;
        logic        [31:0] mag;
        int unsigned        hb;
        sa   = {{32{a[31]}}, a};
        sb_v = {{32{b[31]}}, b};
        mag  = b;
        if (op == UMULL_OP) begin
            p       = {32'd0, a} * {32'd0, b};
            e.lo    = p[31:0];
            e.hi    = p[63:32];
            e.flags = {p[63], p == 64'd0};
        end else if (op == SMULL_OP) begin
            p       = sa * sb_v;
            e.lo    = p[31:0];
            e.hi    = p[63:32];
            e.flags = {p[63], p == 64'd0};
            if (b[31]) mag = -b;
        end else begin
            e.lo    = a * b;
            e.hi    = 32'd0;
            e.flags = {e.lo[31], e.lo == 32'd0};
        end
`ifdef MUL_EARLY_TERM_EN
        hb = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) hb = i;
        e.lat = hb + 1 + 2;
`else
        e.lat = MUL_CYCLES;
`endif
        return e;
    endfunction

    // Issue one multiply; operands are scrambled after acceptance so the
    // latched copies are exercised. 'disturb' re-pulses start and changes
    // SrcA during RUN, and asserts start in the DONE cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb);
        exp_t        e;
        int unsigned cyc;
        int unsigned extra;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        MulCtrl = op;
        SrcA    = a;
        SrcB    = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        MulCtrl = 3'($urandom);
        SrcA    = $urandom;
        SrcB    = $urandom;
        cyc     = 1;
        while (!done && cyc < 100) begin
            check_eq("busy_run", busy, 1);
            if (disturb && cyc == 1) begin
                start = 1'b1;
                SrcA  = 32'hDEAD_BEEF;
            end else if (disturb && cyc == 2) begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        check_eq("latency", cyc, e.lat);
        check_eq("busy_done", busy, 0);
        check_eq("lo", ResultLo, e.lo);
        check_eq("hi", ResultHi, e.hi);
        check_eq("flags", MulFlags, e.flags);
        if (disturb) start = 1'b1;
        @(negedge clk);
        check_eq("done_pulse", done, 0);
        start = 1'b0;
        if (disturb) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            check_eq("no_extra_op", extra, 0);
            check_eq("lo_held", ResultLo, e.lo);
        end
    endtask

    task automatic reset_mid_op();
        int unsigned extra;
        @(negedge clk);
        MulCtrl = UMULL_OP;
        SrcA    = 32'hFFFF_FFFF;
        SrcB    = 32'hFFFF_FFFF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        check_eq("busy_c10", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_lo", ResultLo, 0);
        check_eq("rst_hi", ResultHi, 0);
        check_eq("rst_flags", MulFlags, 0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check_eq("rst_no_done", extra, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ops [5];
        ops[0] = MUL_OP;
        ops[1] = UMULL_OP;
        ops[2] = SMULL_OP;
        ops[3] = 3'b111;
        ops[4] = 3'b000;

        reset   = 1'b1;
        start   = 1'b1;
        MulCtrl = MUL_OP;
        SrcA    = 32'd3;
        SrcB    = 32'd3;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_lo", ResultLo, 0);
        check_eq("reset_hi", ResultHi, 0);
        check_eq("reset_flags", MulFlags, 0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", busy, 0);

        run_op(MUL_OP,   32'd7,         32'd6,         1'b0);
        run_op(UMULL_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(SMULL_OP, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        reset_mid_op();
        run_op(MUL_OP,   32'd3,         32'd5,         1'b0);
        run_op(SMULL_OP, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(MUL_OP,   32'h0000_1234, 32'd0,         1'b1);
        run_op(3'b111,   32'd4,         32'd5,         1'b0);
        run_op(SMULL_OP, 32'h0000_0003, 32'hFFFF_FFF9, 1'b0);
        run_op(UMULL_OP, 32'd0,         32'h0000_0001, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_op(ops[$urandom_range(0, 4)], $urandom, $urandom >> $urandom_range(0, 31), 1'b0);
        end

        check_eq("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
